// File: rtl/scroll_code_sequencer.sv
// Scrolls "dE10" across NUM_DIGITS seven-segment digits as 2-bit character codes; codes follow pos with no added latency.
// No backpressure: auto-rotate every PRESCALE cycles while run=1, or one step per debounced button press while stopped.
module scroll_code_sequencer #(
   parameter int NUM_DIGITS = 6,
   parameter int PRESCALE   = 50_000_000
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    run,
   input  logic                    dir,
   input  logic                    step_btn,
   output logic [2*NUM_DIGITS-1:0] codes,
   output logic [1:0]              pos,
   output logic                    advance
);

   localparam int            CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CW-1:0] TERM = CW'(PRESCALE - 1);

   typedef enum logic {ST_STOP, ST_RUN} state_t;

   state_t        r_state, w_state_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic [1:0]    r_pos;
   logic          r_adv;
   logic          r_sync1, r_sync2, r_prev;
   logic          w_fall;
   logic          w_adv_now;

   // Synchronizer and edge register reset to "released" so reset never fakes a press.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_prev  <= 1'b1;
      end else begin
         r_sync1 <= step_btn;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   assign w_fall = r_prev & ~r_sync2;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = '0;
      w_adv_now   = 1'b0;
      case (r_state)
         ST_STOP: begin
            if (run)
               w_state_nxt = ST_RUN;
            else if (w_fall)
               w_adv_now = 1'b1;
         end
         ST_RUN: begin
            // Leaving RUN discards a terminal count landing in the same cycle.
            if (!run)
               w_state_nxt = ST_STOP;
            else if (r_cnt == TERM)
               w_adv_now = 1'b1;
            else
               w_cnt_nxt = r_cnt + 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_STOP;
         r_cnt   <= '0;
         r_pos   <= 2'd0;
         r_adv   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_adv   <= w_adv_now;
         if (w_adv_now)
            r_pos <= dir ? (r_pos - 2'd1) : (r_pos + 2'd1);
      end
   end

   // Leftmost digit shows pos itself; each digit to the right is one code further along.
   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
      assign codes[2*g +: 2] = r_pos + 2'((NUM_DIGITS - 1 - g) % 4);
   end

   assign pos     = r_pos;
   assign advance = r_adv;

endmodule

// File: tb/tb_scroll_code_sequencer.sv
// Directed bench for scroll_code_sequencer with NUM_DIGITS=6, PRESCALE=4.
module tb_scroll_code_sequencer;

   logic        clk = 1'b0;
   logic        clk_en = 1'b0;
   logic        reset = 1'b0;
   logic        run = 1'b0;
   logic        dir = 1'b0;
   logic        step_btn = 1'b1;
   logic [11:0] codes;
   logic [1:0]  pos;
   logic        advance;

   int n_pass = 0;
   int n_total = 0;

   scroll_code_sequencer #(.NUM_DIGITS(6), .PRESCALE(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .run      (run),
      .dir      (dir),
      .step_btn (step_btn),
      .codes    (codes),
      .pos      (pos),
      .advance  (advance)
   );

   always begin
      #5;
      if (clk_en) clk = ~clk;
   end

   typedef struct {
      logic       run;
      logic       dir;
      logic       step;
      logic [1:0] pos;
      logic       adv;
   } vec_t;

   vec_t tv[$];

   function automatic logic [11:0] exp_codes(input logic [1:0] p);
      case (p)
         2'd0:    return 12'h1B1;
         2'd1:    return 12'h6C6;
         2'd2:    return 12'hB1B;
         default: return 12'hC6C;
      endcase
   endfunction

   function automatic void add(input int n, input logic r, input logic d, input logic s,
                               input logic [1:0] p, input logic a);
      vec_t v;
      v.run = r; v.dir = d; v.step = s; v.pos = p; v.adv = a;
      for (int k = 0; k < n; k++) tv.push_back(v);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   task automatic chk_all(input string name, input logic [1:0] p, input logic a);
      chk({name, ".pos"}, 32'(pos), 32'(p));
      chk({name, ".adv"}, 32'(advance), 32'(a));
      chk({name, ".codes"}, 32'(codes), 32'(exp_codes(p)));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Auto-rotate left from reset: the entry edge, then an advance every 4th edge.
      add(4, 1, 0, 1, 2'd0, 0); add(1, 1, 0, 1, 2'd1, 1);
      add(3, 1, 0, 1, 2'd1, 0); add(1, 1, 0, 1, 2'd2, 1);
      add(3, 1, 0, 1, 2'd2, 0); add(1, 1, 0, 1, 2'd3, 1);
      add(3, 1, 0, 1, 2'd3, 0); add(1, 1, 0, 1, 2'd0, 1);
      // Stop, then hold the button low 10 cycles: one step on the 3rd edge; release and dir alone do nothing.
      add(1, 0, 0, 1, 2'd0, 0);
      add(2, 0, 0, 0, 2'd0, 0); add(1, 0, 0, 0, 2'd1, 1); add(7, 0, 0, 0, 2'd1, 0);
      add(5, 0, 1, 1, 2'd1, 0);
      // Synchronized fall coincides with run rising, then another fall during RUN: both ignored.
      add(2, 0, 0, 0, 2'd1, 0); add(1, 1, 0, 0, 2'd1, 0);
      add(2, 1, 0, 1, 2'd1, 0); add(1, 1, 0, 0, 2'd1, 0);
      add(1, 1, 0, 0, 2'd2, 1); add(3, 1, 0, 0, 2'd2, 0);
      add(1, 1, 0, 0, 2'd3, 1); add(3, 0, 0, 0, 2'd3, 0);

      // Reset without any clock.
      reset = 1'b1;
      #3;
      chk_all("reset_noclk", 2'd0, 1'b0);
      reset = 1'b0;
      #2;
      clk_en = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk_all($sformatf("idle%0d", i), 2'd0, 1'b0);
      end

      foreach (tv[i]) begin
         run = tv[i].run; dir = tv[i].dir; step_btn = tv[i].step;
         tick();
         chk_all($sformatf("vec%0d", i), tv[i].pos, tv[i].adv);
      end

      // Rotate right from reset.
      run = 1'b0; step_btn = 1'b1;
      reset = 1'b1; #2; reset = 1'b0;
      run = 1'b1; dir = 1'b1;
      for (int e = 1; e <= 17; e++) begin
         tick();
         if (e == 4)  chk_all("right_e4", 2'd0, 1'b0);
         if (e == 5)  chk_all("right_first", 2'd3, 1'b1);
         if (e == 17) chk_all("right_fourth", 2'd0, 1'b1);
      end

      // Reset mid-count at pos=2, prescaler=2.
      run = 1'b0; dir = 1'b0;
      reset = 1'b1; #2; reset = 1'b0;
      run = 1'b1;
      repeat (11) tick();
      chk("midcount.pos", 32'(pos), 32'd2);
      reset = 1'b1;
      #1;
      chk_all("midreset", 2'd0, 1'b0);
      tick();
      reset = 1'b0;
      // First edge after release enters RUN; the advance lands four edges after that.
      for (int e = 1; e <= 5; e++) begin
         tick();
         if (e < 5) chk_all($sformatf("post_reset_e%0d", e), 2'd0, 1'b0);
         else       chk_all("post_reset_adv", 2'd1, 1'b1);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
